elevator_call_panel: RTL and testbench
======================================

# elevator_call_panel

Button-side front end for the elevator controller: debounces the raw hall-up, hall-down and in-car buttons and turns each new press into a one-cycle request pulse on the controller's `btup`/`btdn`/`in_bt_floor` inputs. It also drives the call lamps. Each lamp stays lit until the controller opens the door at the served floor. The block sits between the physical button matrix and the controller, and tracks service from the controller's `floor`, door and direction outputs.

## Interface
Parameters:
- `DB_CYCLES`, default 4: consecutive stable samples needed to accept a button level change (legal range 1..15).
- `DB_W`, default 4: width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports (clock and reset first):
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset, asynchronous, active-low.
- `raw_up`  in  [7:1]: raw hall-up buttons, floors 1..7.
- `raw_dn`  in  [8:2]: raw hall-down buttons, floors 2..8.
- `raw_car`  in  [8:1]: raw in-car floor buttons.
- `floor`  in  [8:1]: controller's current floor, one-hot.
- `door_open`  in  1: controller is in the door-open state.
- `dir_up`  in  1: controller is moving up.
- `dir_dn`  in  1: controller is moving down.
- `btup`  out  [7:1]: hall-up request pulses, one cycle each.
- `btdn`  out  [8:2]: hall-down request pulses, one cycle each.
- `in_bt_floor`  out  [8:1]: car request pulses, one cycle each.
- `lamp_up`  out  [7:1]: lit hall-up lamps.
- `lamp_dn`  out  [8:2]: lit hall-down lamps.
- `lamp_car`  out  [8:1]: lit car lamps.
- `pend_cnt`  out  [4:0]: number of lit lamps (0..22).
- `any_call`  out  1: high when `pend_cnt` != 0.

## Operation
- Input stage: each raw bit is registered once (`ireg`) before any other logic.
- Debounce: each button has a level `deb` and a counter.
  - If `ireg` != `deb`, the counter increments. When it reaches `DB_CYCLES`, `deb` toggles and the counter clears.
  - If `ireg` == `deb`, the counter clears.
- Press event: a rising edge of `deb`, detected by `deb & ~deb_d`.
- Direction memory `last_up`:
  - Reset value 1.
  - Set by `dir_up`, cleared by `dir_dn`, otherwise held. If both are high, it is set.
- Service (clear) conditions, all requiring `door_open` and `floor[f]`:
  - Car lamp f: `door_open & floor[f]`.
  - Up lamp f: `door_open & floor[f] & (last_up | f==1)`.
  - Down lamp f: `door_open & floor[f] & (~last_up | f==8)`.
- A press event on button b produces a pulse and sets lamp b only when lamp b is off and b's clear condition is false.
  - A press on an already-lit button produces no pulse.
  - A press at the floor currently being served produces neither pulse nor lamp.
- Clear and press on the same lamp in the same cycle: the clear wins.
- `pend_cnt` is the registered popcount of the next lamp vector, so it always matches the lamps in the same cycle. `any_call` is derived from it.

## Timing
- Reset values: all pulses, lamps, `pend_cnt`, `any_call`, `ireg`, `deb`, `deb_d` and counters are 0; `last_up` is 1.
- After reset, a button held across reset release is treated as a new press and produces one pulse.
- With `ELEV_DEBOUNCE_EN` defined:
  - If raw is first sampled high at edge k and stays stable, `deb` rises at edge k+`DB_CYCLES`.
  - The pulse and lamp are registered at edge k+`DB_CYCLES`+1.
- Pulse width is exactly one clock. The controller samples it on the next posedge.
- Lamp clear happens on the first posedge at which the clear condition is true.
- A bounce shorter than `DB_CYCLES` samples resets the counter and produces no event.
- Release is debounced symmetrically. A new pulse requires a release followed by a new press.
- Reset asserted mid-debounce or mid-pulse clears everything immediately (asynchronous).

## Configuration
- `ELEV_DEBOUNCE_EN` defined: debounce counters present, behaving as above.
- `ELEV_DEBOUNCE_EN` undefined: counters removed and `deb` = `ireg`. The pulse is registered at edge k+1, one edge after the raw level is first sampled. `DB_CYCLES` and `DB_W` are ignored.

## Test plan
- Single up press: `DB_CYCLES`=4, macro on; `raw_up[3]` high from edge 10 → `btup[3]` high for exactly the cycle after edge 15; `lamp_up[3]`=1; `pend_cnt`=1.
- Bounce rejection: `raw_car[5]` high for 3 samples, low 1, high 3 → no pulse, `lamp_car[5]`=0.
- Repeat press suppression: `raw_dn[6]` pressed, released, pressed again while lamp is lit → exactly one `btdn[6]` pulse.
- Service clear: lamps car[4], up[4], dn[4] lit; `last_up`=1; `floor`=8'b0000_1000 with `door_open`=1 → car[4] and up[4] clear on the next edge, dn[4] stays lit, `pend_cnt`=1.
- Terminal floor: `last_up`=1, `floor`=8'b1000_0000, `door_open`=1 with dn[8] lit → dn[8] clears; a new `raw_dn[8]` press while the door is open gives no pulse.
- Reset mid-operation: assert `rst` with 5 lamps lit and `raw_up[1]` held → all outputs 0 immediately; after release, one `btup[1]` pulse at edge `DB_CYCLES`+1 after the first sampling edge.

Source files
------------

// File: rtl/elevator_call_panel.sv
// elevator_call_panel
//
// Button-side front end for the elevator controller. Raw hall-up, hall-down
// and in-car buttons are registered, debounced and edge-detected. Each new
// press becomes a one-cycle request pulse to the controller. Each press also
// lights a call lamp, which stays lit until the controller opens the door at
// the served floor.
//
// Build option:
//   ELEV_DEBOUNCE_EN  defined   -> per-button debounce counters; a level change
//                                  is accepted after DB_CYCLES stable samples.
//                     undefined -> no counters; the debounced level is the
//                                  registered raw level, and DB_CYCLES/DB_W
//                                  are ignored.
//
// Parameters:
//   DB_CYCLES    stable samples needed to accept a level change (1..15)
//   DB_W         debounce counter width, 2**DB_W > DB_CYCLES
//
// Ports:
//   clk          clock, posedge
//   rst          asynchronous active-low reset
//   raw_up       [7:1] raw hall-up buttons
//   raw_dn       [8:2] raw hall-down buttons
//   raw_car      [8:1] raw in-car buttons
//   floor        [8:1] controller's current floor, one-hot
//   door_open    controller is in the door-open state
//   dir_up       controller moving up
//   dir_dn       controller moving down
//   btup         [7:1] hall-up request pulses
//   btdn         [8:2] hall-down request pulses
//   in_bt_floor  [8:1] car request pulses
//   lamp_up      [7:1] lit hall-up lamps
//   lamp_dn      [8:2] lit hall-down lamps
//   lamp_car     [8:1] lit car lamps
//   pend_cnt     [4:0] number of lit lamps
//   any_call     pend_cnt != 0
module elevator_call_panel #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:1] raw_up,
    input  logic [8:2] raw_dn,
    input  logic [8:1] raw_car,
    input  logic [8:1] floor,
    input  logic       door_open,
    input  logic       dir_up,
    input  logic       dir_dn,
    output logic [7:1] btup,
    output logic [8:2] btdn,
    output logic [8:1] in_bt_floor,
    output logic [7:1] lamp_up,
    output logic [8:2] lamp_dn,
    output logic [8:1] lamp_car,
    output logic [4:0] pend_cnt,
    output logic       any_call
);

    // All 22 buttons are handled as one vector:
    //   [6:0]   hall-up   floors 1..7
    //   [13:7]  hall-down floors 2..8
    //   [21:14] car       floors 1..8
    localparam int unsigned N = 22;

    // Empty marker scope that shows up in the hierarchy when the debounce
    // parameters are out of their legal range.
    if ((DB_CYCLES < 1) || (DB_CYCLES > 15) || ((1 << DB_W) <= DB_CYCLES)) begin : g_bad_debounce_cfg
    end

    logic [N-1:0] raw_all;
    logic [N-1:0] ireg_q;
    logic [N-1:0] deb;
    logic [N-1:0] deb_dly_q;
    logic [N-1:0] clr;
    logic [N-1:0] press;
    logic [N-1:0] pulse_q, pulse_d;
    logic [N-1:0] lamp_q, lamp_d;
    logic [4:0]   pend_q, pend_d;
    logic         last_up_q, last_up_d;

    assign raw_all = {raw_car, raw_dn, raw_up};

`ifdef ELEV_DEBOUNCE_EN
    logic [N-1:0]           deb_q, deb_d;
    logic [N-1:0][DB_W-1:0] cnt_q, cnt_d;

    // A level change is accepted once the registered input has disagreed
    // with the debounced level for DB_CYCLES consecutive samples; any
    // agreeing sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int unsigned b = 0; b < N; b++) begin
            if (ireg_q[b] != deb_q[b]) begin
                if (cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
                    deb_d[b] = ~deb_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb = deb_q;
`else
    assign deb = ireg_q;
`endif

    // Service conditions. Hall lamps clear only when the car is leaving in
    // the lamp's direction; the terminal floors have one hall button and
    // always serve it.
    always_comb begin
        clr = '0;
        for (int unsigned f = 1; f <= 7; f++) begin
            clr[f-1] = door_open & floor[f] & (last_up_q | (f == 1));
        end
        for (int unsigned f = 2; f <= 8; f++) begin
            clr[f+5] = door_open & floor[f] & (~last_up_q | (f == 8));
        end
        for (int unsigned f = 1; f <= 8; f++) begin
            clr[f+13] = door_open & floor[f];
        end
    end

    // A press pulses and lights the lamp only when the lamp is dark and the
    // floor is not being served right now; a clear always wins.
    always_comb begin
        press   = deb & ~deb_dly_q;
        pulse_d = press & ~lamp_q & ~clr;
        lamp_d  = (lamp_q | pulse_d) & ~clr;
        pend_d  = '0;
        for (int unsigned b = 0; b < N; b++) begin
            pend_d = pend_d + 5'(lamp_d[b]);
        end
    end

    always_comb begin
        last_up_d = last_up_q;
        if (dir_up) begin
            last_up_d = 1'b1;
        end else if (dir_dn) begin
            last_up_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ireg_q    <= '0;
            deb_dly_q <= '0;
            pulse_q   <= '0;
            lamp_q    <= '0;
            pend_q    <= '0;
            last_up_q <= 1'b1;
        end else begin
            ireg_q    <= raw_all;
            deb_dly_q <= deb;
            pulse_q   <= pulse_d;
            lamp_q    <= lamp_d;
            pend_q    <= pend_d;
            last_up_q <= last_up_d;
        end
    end

    assign btup        = pulse_q[6:0];
    assign btdn        = pulse_q[13:7];
    assign in_bt_floor = pulse_q[21:14];
    assign lamp_up     = lamp_q[6:0];
    assign lamp_dn     = lamp_q[13:7];
    assign lamp_car    = lamp_q[21:14];
    assign pend_cnt    = pend_q;
    assign any_call    = (pend_q != 5'd0);

endmodule

// File: tb/tb_elevator_call_panel.sv
module tb_elevator_call_panel;

    localparam int unsigned DB = 4;
`ifdef ELEV_DEBOUNCE_EN
    localparam int LAT = DB + 1;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:1] raw_up = '0;
    logic [8:2] raw_dn = '0;
    logic [8:1] raw_car = '0;
    logic [8:1] floor = 8'b0000_0001;
    logic       door_open = 1'b0;
    logic       dir_up = 1'b0;
    logic       dir_dn = 1'b0;
    logic [7:1] btup;
    logic [8:2] btdn;
    logic [8:1] in_bt_floor;
    logic [7:1] lamp_up;
    logic [8:2] lamp_dn;
    logic [8:1] lamp_car;
    logic [4:0] pend_cnt;
    logic       any_call;

    elevator_call_panel #(.DB_CYCLES(DB), .DB_W(4)) dut (
        .clk(clk), .rst(rst),
        .raw_up(raw_up), .raw_dn(raw_dn), .raw_car(raw_car),
        .floor(floor), .door_open(door_open), .dir_up(dir_up), .dir_dn(dir_dn),
        .btup(btup), .btdn(btdn), .in_bt_floor(in_bt_floor),
        .lamp_up(lamp_up), .lamp_dn(lamp_dn), .lamp_car(lamp_car),
        .pend_cnt(pend_cnt), .any_call(any_call)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons numbered 0..21: up floors 1..7, down floors 2..8, car floors 1..8.
    int          hist [22][16];   // hist[b][i]: raw sample taken i+1 edges ago
    bit          m_deb [22];
    bit          m_deb_prev [22];
    logic [21:0] m_lamp;
    logic [21:0] m_pulse;
    bit          m_last_up;

    function automatic int floor_of(input int b);
        if (b < 7) return b + 1;
        if (b < 14) return b - 5;
        return b - 13;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 22; b++) begin
                for (int i = 0; i < 16; i++) hist[b][i] = 0;
                m_deb[b] = 0;
                m_deb_prev[b] = 0;
            end
            m_lamp = '0;
            m_pulse = '0;
            m_last_up = 1;
        end else begin
            logic [21:0] rv;
            rv = {raw_car, raw_dn, raw_up};
            for (int b = 0; b < 22; b++) begin
                int  f;
                bit  served;
                bit  pr;
                f = floor_of(b);
                served = door_open && floor[f];
                if (b < 7)       served = served && (m_last_up || f == 1);
                else if (b < 14) served = served && (!m_last_up || f == 8);
                pr = m_deb[b] && !m_deb_prev[b];
                m_pulse[b] = pr && !m_lamp[b] && !served;
                m_lamp[b] = (m_lamp[b] || m_pulse[b]) && !served;
                m_deb_prev[b] = m_deb[b];
`ifdef ELEV_DEBOUNCE_EN
                begin
                    bit all_diff;
                    all_diff = 1;
                    for (int i = 0; i < int'(DB); i++)
                        if (hist[b][i] == int'(m_deb[b])) all_diff = 0;
                    if (all_diff) m_deb[b] = !m_deb[b];
                end
`else
                m_deb[b] = rv[b];
`endif
                for (int i = 15; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = int'(rv[b]);
            end
            if (dir_up) m_last_up = 1;
            else if (dir_dn) m_last_up = 0;
        end
    end

    // Every cycle out of reset, all outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            int cnt;
            cnt = $countones(m_lamp);
            chk("btup", int'(btup), int'(m_pulse[6:0]));
            chk("btdn", int'(btdn), int'(m_pulse[13:7]));
            chk("in_bt_floor", int'(in_bt_floor), int'(m_pulse[21:14]));
            chk("lamp_up", int'(lamp_up), int'(m_lamp[6:0]));
            chk("lamp_dn", int'(lamp_dn), int'(m_lamp[13:7]));
            chk("lamp_car", int'(lamp_car), int'(m_lamp[21:14]));
            chk("pend_cnt", int'(pend_cnt), cnt);
            chk("any_call", int'(any_call), int'(cnt != 0));
            pulse_total += $countones({btup, btdn, in_bt_floor});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_out"}, int'({btup, btdn, in_bt_floor, lamp_up, lamp_dn, lamp_car}), 0);
        chk({nm, "_pend"}, int'(pend_cnt), 0);
        chk({nm, "_any"}, int'(any_call), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("reset");
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        // reset state
        tick(2);
        chk_all_zero("por");
        rst = 1'b1;
        tick(3);

        // single up press
        raw_up[3] = 1'b1;
        tick(LAT);
        chk("up3_early", int'(btup), 0);
        tick(1);
        chk("up3_pulse", int'(btup), 'h04);
        chk("up3_lamp", int'(lamp_up), 'h04);
        chk("up3_pend", int'(pend_cnt), 1);
        chk("up3_any", int'(any_call), 1);
        tick(1);
        chk("up3_width", int'(btup), 0);
        raw_up[3] = 1'b0;
        tick(LAT + 2);

`ifdef ELEV_DEBOUNCE_EN
        // bounce rejection
        raw_car[5] = 1'b1; tick(3);
        raw_car[5] = 1'b0; tick(1);
        raw_car[5] = 1'b1; tick(3);
        raw_car[5] = 1'b0; tick(LAT + 3);
        chk("bounce_lamp", int'(lamp_car[5]), 0);
`endif

        // repeat press suppression
        pulse_total = 0;
        raw_dn[6] = 1'b1; tick(LAT + 2);
        raw_dn[6] = 1'b0; tick(LAT + 2);
        raw_dn[6] = 1'b1; tick(LAT + 2);
        raw_dn[6] = 1'b0; tick(LAT + 2);
        chk("repeat_pulses", pulse_total, 1);
        chk("repeat_lamp", int'(lamp_dn[6]), 1);

        // service clear at floor 4, moving up
        do_reset();
        raw_car[4] = 1'b1; raw_up[4] = 1'b1; raw_dn[4] = 1'b1;
        tick(LAT + 2);
        raw_car[4] = 1'b0; raw_up[4] = 1'b0; raw_dn[4] = 1'b0;
        tick(LAT + 2);
        chk("svc_pend_before", int'(pend_cnt), 3);
        floor = 8'b0000_1000; door_open = 1'b1;
        tick(1);
        chk("svc_car4", int'(lamp_car[4]), 0);
        chk("svc_up4", int'(lamp_up[4]), 0);
        chk("svc_dn4", int'(lamp_dn[4]), 1);
        chk("svc_pend", int'(pend_cnt), 1);
        door_open = 1'b0; floor = 8'b0000_0001;
        tick(2);

        // terminal floor 8
        raw_dn[8] = 1'b1; tick(LAT + 2);
        raw_dn[8] = 1'b0; tick(LAT + 2);
        chk("term_lit", int'(lamp_dn[8]), 1);
        floor = 8'b1000_0000; door_open = 1'b1;
        tick(1);
        chk("term_clear", int'(lamp_dn[8]), 0);
        pulse_total = 0;
        raw_dn[8] = 1'b1; tick(LAT + 2);
        chk("term_nopulse", pulse_total, 0);
        chk("term_nolamp", int'(lamp_dn[8]), 0);
        raw_dn[8] = 1'b0; tick(LAT + 2);
        door_open = 1'b0; floor = 8'b0000_0001;
        tick(2);

        // direction memory: moving down serves dn5, then up serves up5
        raw_up[5] = 1'b1; raw_dn[5] = 1'b1; tick(LAT + 2);
        raw_up[5] = 1'b0; raw_dn[5] = 1'b0; tick(LAT + 2);
        dir_dn = 1'b1; tick(1); dir_dn = 1'b0;
        floor = 8'b0001_0000; door_open = 1'b1;
        tick(1);
        chk("dir_dn5_clear", int'(lamp_dn[5]), 0);
        chk("dir_up5_kept", int'(lamp_up[5]), 1);
        dir_up = 1'b1; tick(1); dir_up = 1'b0;
        tick(1);
        chk("dir_up5_clear", int'(lamp_up[5]), 0);
        door_open = 1'b0; floor = 8'b0000_0001;
        tick(2);

        // reset mid-operation with raw_up[1] held
        do_reset();
        raw_car[1] = 1'b1; raw_car[2] = 1'b1; raw_car[3] = 1'b1; raw_up[2] = 1'b1;
        tick(LAT + 2);
        raw_car[1] = 1'b0; raw_car[2] = 1'b0; raw_car[3] = 1'b0; raw_up[2] = 1'b0;
        raw_up[1] = 1'b1;
        tick(LAT + 2);
        chk("mid_pend5", int'(pend_cnt), 5);
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick(2);
        rst = 1'b1;
        tick(LAT);
        chk("mid_up1_early", int'(btup), 0);
        tick(1);
        chk("mid_up1_pulse", int'(btup), 'h01);
        tick(1);
        chk("mid_up1_width", int'(btup), 0);
        raw_up[1] = 1'b0;
        tick(LAT + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
